// File: rtl/serial_nibble_loader_pkg.sv
// Shared definitions for the serial nibble loader: FSM state encoding and
// frame-length helper.
package serial_nibble_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Serial bits per frame: the data bits plus an optional parity bit.
    function automatic int frame_len(input int width, input bit parity_en);
        return width + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// WIDTH-bit serial-in shift register with synchronous clear; MSB_FIRST picks
// the end where the first received bit finally lands.
module serial_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_shifted
);

    // q_shifted lets the owner commit the word on the same edge as the last bit.
    always_comb begin
        if (MSB_FIRST) begin
            q_shifted = {q[WIDTH-2:0], bit_in};
        end else begin
            q_shifted = {bit_in, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= q_shifted;
        end
    end

endmodule

// File: rtl/serial_nibble_loader.sv
// Frames a serial bit stream into a WIDTH-bit word and hands it to the
// downstream enabled D-register bank with a one-cycle ENABLE strobe.
module serial_nibble_loader
    import serial_nibble_loader_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic             SERIAL_VALID,
    input  logic             SERIAL_IN,
    output logic [WIDTH-1:0] D,
    output logic             ENABLE,
    output logic             BUSY,
    output logic             PAR_ERR
);

    localparam int                FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int                CNT_W     = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  DATA_CNT  = CNT_W'(WIDTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              sample, shift_en, accept_start, commit, set_perr, par_bad;
    logic [WIDTH-1:0]  sr_q, sr_shifted, word;

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .clr       (accept_start),
        .shift_en  (shift_en),
        .bit_in    (SERIAL_IN),
        .q         (sr_q),
        .q_shifted (sr_shifted)
    );

    // With parity the word is already complete when the parity bit arrives.
    assign shift_en = sample && (cnt_q < DATA_CNT);
    assign word     = PARITY_EN ? sr_q : sr_shifted;
    assign par_bad  = ^{sr_q, SERIAL_IN};

    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        commit       = 1'b0;
        set_perr     = 1'b0;
        sample       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ABORT && START) begin
                    state_d      = ST_SHIFT;
                    accept_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (SERIAL_VALID) begin
                    sample = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        if (PARITY_EN && par_bad) begin
                            state_d  = ST_IDLE;
                            set_perr = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                            commit  = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ENABLE and BUSY are registered copies of the next-state decode.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            D       <= '0;
            ENABLE  <= 1'b0;
            BUSY    <= 1'b0;
            PAR_ERR <= 1'b0;
        end else begin
            state_q <= state_d;
            ENABLE  <= commit;
            BUSY    <= (state_d != ST_IDLE);
            if (state_d != ST_SHIFT) begin
                cnt_q <= '0;
            end else if (sample) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (commit) begin
                D <= word;
            end
            if (accept_start) begin
                PAR_ERR <= 1'b0;
            end else if (set_perr) begin
                PAR_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Directed bench: three loader configurations (MSB-first, LSB-first, parity)
// on shared serial inputs with per-instance START.
module tb_serial_nibble_loader;

    logic       CLOCK, RESET, ABORT, SERIAL_VALID, SERIAL_IN;
    logic       start_a, start_b, start_c;
    logic [3:0] d_a, d_b, d_c, q_a;
    logic       en_a, en_b, en_c, busy_a, busy_b, busy_c, perr_a, perr_b, perr_c;
    int         n_cmp, n_bad;
    int         n_en_a, n_en_b, n_en_c, base;
    logic       busy_ok;
    logic       bits_b [4];

    serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .START(start_a), .ABORT(ABORT),
        .SERIAL_VALID(SERIAL_VALID), .SERIAL_IN(SERIAL_IN),
        .D(d_a), .ENABLE(en_a), .BUSY(busy_a), .PAR_ERR(perr_a));

    serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .START(start_b), .ABORT(ABORT),
        .SERIAL_VALID(SERIAL_VALID), .SERIAL_IN(SERIAL_IN),
        .D(d_b), .ENABLE(en_b), .BUSY(busy_b), .PAR_ERR(perr_b));

    serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_c (
        .CLOCK(CLOCK), .RESET(RESET), .START(start_c), .ABORT(ABORT),
        .SERIAL_VALID(SERIAL_VALID), .SERIAL_IN(SERIAL_IN),
        .D(d_c), .ENABLE(en_c), .BUSY(busy_c), .PAR_ERR(perr_c));

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Downstream register bank fed by instance A.
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET)    q_a <= 4'd0;
        else if (en_a) q_a <= d_a;
    end

    always @(posedge CLOCK) begin
        if (en_a) n_en_a <= n_en_a + 1;
        if (en_b) n_en_b <= n_en_b + 1;
        if (en_c) n_en_c <= n_en_c + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        SERIAL_VALID = 1'b1;
        SERIAL_IN    = b;
        step();
        SERIAL_VALID = 1'b0;
        SERIAL_IN    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        n_en_a = 0; n_en_b = 0; n_en_c = 0;
        RESET = 1'b0; ABORT = 1'b0; SERIAL_VALID = 1'b0; SERIAL_IN = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        bits_b = '{1'b1, 1'b1, 1'b0, 1'b0};
        repeat (2) @(posedge CLOCK);
        #1;
        chk("rst_d", d_a, 0);
        chk("rst_en", en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_perr", perr_c, 0);
        RESET = 1'b1;
        step();

        // MSB-first frame 1011
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("start_busy", busy_a, 1);
        shift_bit(1); shift_bit(0); shift_bit(1);
        chk("en_early", en_a, 0);
        shift_bit(1);
        chk("a_d", d_a, 4'b1011);
        chk("a_en", en_a, 1);
        chk("a_busy_load", busy_a, 1);
        step();
        chk("a_en_1cyc", en_a, 0);
        chk("a_q", q_a, 4'b1011);
        chk("a_busy_off", busy_a, 0);
        chk("a_pulses", n_en_a, 1);
        base = n_en_a;

        // ABORT together with the final bit
        start_a = 1'b1; step(); start_a = 1'b0;
        shift_bit(1); shift_bit(0); shift_bit(1);
        ABORT = 1'b1; shift_bit(0); ABORT = 1'b0;
        chk("abort_en", en_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_d", d_a, 4'b1011);
        step();
        chk("abort_pulses", n_en_a, base);

        // START while busy is ignored; frame 0110 completes
        start_a = 1'b1; step(); start_a = 1'b0;
        shift_bit(0);
        start_a = 1'b1; shift_bit(1); start_a = 1'b0;
        shift_bit(1); shift_bit(0);
        chk("busy_start_d", d_a, 4'b0110);
        chk("busy_start_en", en_a, 1);
        step();
        chk("busy_start_pulses", n_en_a, base + 1);

        // Back-to-back frames 0101 then 1110
        start_a = 1'b1; step(); start_a = 1'b0;
        shift_bit(0); shift_bit(1); shift_bit(0); shift_bit(1);
        chk("b2b_d1", d_a, 4'b0101);
        chk("b2b_en1", en_a, 1);
        step();
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("b2b_busy2", busy_a, 1);
        shift_bit(1); shift_bit(1); shift_bit(1); shift_bit(0);
        chk("b2b_d2", d_a, 4'b1110);
        chk("b2b_en2", en_a, 1);
        step();
        chk("b2b_en_off", en_a, 0);
        chk("b2b_q", q_a, 4'b1110);
        chk("b2b_pulses", n_en_a, base + 3);
        base = n_en_a;

        // Reset in the middle of a frame
        start_a = 1'b1; step(); start_a = 1'b0;
        shift_bit(1); shift_bit(1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_d", d_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_en", en_a, 0);
        step();
        RESET = 1'b1;
        shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(1);
        step();
        chk("mid_rst_pulses", n_en_a, base);
        chk("mid_rst_d_after", d_a, 0);

        // LSB-first with valid on every other cycle
        busy_ok = 1'b1;
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift_bit(bits_b[i]);
            if (i < 3) begin
                busy_ok = busy_ok & busy_b & ~en_b;
                step();
                busy_ok = busy_ok & busy_b & ~en_b;
            end
        end
        chk("lsb_busy_span", busy_ok, 1);
        chk("lsb_d", d_b, 4'b0011);
        chk("lsb_en", en_b, 1);
        step();
        chk("lsb_en_off", en_b, 0);
        chk("lsb_busy_off", busy_b, 0);
        chk("lsb_pulses", n_en_b, 1);

        // Parity: good frame then bad frame
        start_c = 1'b1; step(); start_c = 1'b0;
        shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(1);
        chk("par_no_en_at_data", en_c, 0);
        shift_bit(1);
        chk("par_good_d", d_c, 4'b1011);
        chk("par_good_en", en_c, 1);
        chk("par_good_perr", perr_c, 0);
        step();
        start_c = 1'b1; step(); start_c = 1'b0;
        shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(1); shift_bit(0);
        chk("par_bad_perr", perr_c, 1);
        chk("par_bad_en", en_c, 0);
        chk("par_bad_busy", busy_c, 0);
        chk("par_bad_d", d_c, 4'b1011);
        step();
        chk("par_pulses", n_en_c, 1);
        chk("par_sticky", perr_c, 1);
        start_c = 1'b1; step(); start_c = 1'b0;
        chk("par_clr", perr_c, 0);
        chk("par_restart_busy", busy_c, 1);
        ABORT = 1'b1; step(); ABORT = 1'b0;
        chk("par_abort_busy", busy_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
